// File: rtl/io_channel_unit_pkg.sv
// Shared definitions for the processor I/O channel responder: channel op
// encoding and the write-type predicate.
package io_channel_unit_pkg;

    typedef enum logic [2:0] {
        IO_READ  = 3'd0,
        IO_WRITE = 3'd1,
        IO_RAND  = 3'd2,
        IO_WAND  = 3'd3,
        IO_ROR   = 3'd4,
        IO_WOR   = 3'd5,
        IO_RXOR  = 3'd6
    } io_op_t;

    // One bit per encoding; set for ops that update the addressed channel.
    localparam logic [7:0] IO_WRITE_OPS = 8'b0010_1010;

    function automatic logic is_write_op(input io_op_t op);
        return IO_WRITE_OPS[3'(op)];
    endfunction

endpackage

// File: rtl/io_channel_unit_if.sv
// Processor request/response and peripheral in/out signals of the channel unit.
interface io_channel_unit_if
    import io_channel_unit_pkg::*;
#(
    parameter int unsigned NUM_CHAN = 16,
    parameter int unsigned WIDTH    = 15
) ();
    localparam int unsigned CW = $clog2(NUM_CHAN);

    logic             io_req;
    io_op_t           io_op;
    logic [CW-1:0]    io_chan;
    logic [WIDTH-1:0] io_wdata;
    logic             io_stall;
    logic             io_ack;
    logic [WIDTH-1:0] io_rdata;

    logic             per_in_valid;
    logic [CW-1:0]    per_in_chan;
    logic [WIDTH-1:0] per_in_data;
    logic             per_in_ready;

    logic             per_out_valid;
    logic [CW-1:0]    per_out_chan;
    logic [WIDTH-1:0] per_out_data;
    logic             per_out_ready;

    modport master (
        output io_req, io_op, io_chan, io_wdata,
               per_in_valid, per_in_chan, per_in_data, per_out_ready,
        input  io_stall, io_ack, io_rdata, per_in_ready,
               per_out_valid, per_out_chan, per_out_data
    );

    modport slave (
        input  io_req, io_op, io_chan, io_wdata,
               per_in_valid, per_in_chan, per_in_data, per_out_ready,
        output io_stall, io_ack, io_rdata, per_in_ready,
               per_out_valid, per_out_chan, per_out_data
    );
endinterface

// File: rtl/io_event_fifo.sv
// Synchronous FIFO for outbound channel events; extra pointer bit separates
// full from empty, head is presented combinationally (no fall-through).
module io_event_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clock,
    input  logic             rst_l,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] dout_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A full FIFO may still accept a push when the head leaves this cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    end

    always_ff @(posedge clock or negedge rst_l) begin
        if (!rst_l) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
    end

    // Gate the head so stale storage never shows while empty.
    assign dout_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/io_channel_unit.sv
// Processor-side I/O channel responder: channel register bank, channel-op ALU,
// one-cycle response register and outbound event FIFO for output channels.
module io_channel_unit
    import io_channel_unit_pkg::*;
#(
    parameter int unsigned NUM_CHAN       = 16,
    parameter int unsigned WIDTH          = 15,
    parameter int unsigned OUT_FIFO_DEPTH = 4
) (
    input logic               clock,
    input logic               rst_l,
    io_channel_unit_if.slave  bus
);
    localparam int unsigned CW = $clog2(NUM_CHAN);
    localparam int unsigned EW = CW + WIDTH;

    logic [WIDTH-1:0] chan_q [NUM_CHAN];
    logic [WIDTH-1:0] chan_d [NUM_CHAN];
    logic             io_ack_q, io_ack_d;
    logic [WIDTH-1:0] io_rdata_q, io_rdata_d;

    logic [WIDTH-1:0] r_val, result;
    logic             wr_op, out_chan, accept, wr_en, push, pop, per_wr;
    logic             fifo_full, fifo_empty;
    logic [EW-1:0]    fifo_dout;

    assign r_val    = chan_q[bus.io_chan];
    assign wr_op    = is_write_op(bus.io_op);
    // Lower half of the channel space are output channels.
    assign out_chan = !bus.io_chan[CW-1];

    always_comb begin
        result = r_val;
        case (bus.io_op)
            IO_READ:          result = r_val;
            IO_WRITE:         result = bus.io_wdata;
            IO_RAND, IO_WAND: result = r_val & bus.io_wdata;
            IO_ROR,  IO_WOR:  result = r_val | bus.io_wdata;
            IO_RXOR:          result = r_val ^ bus.io_wdata;
            default:          result = r_val;
        endcase
    end

    assign pop          = bus.per_out_valid && bus.per_out_ready;
    assign bus.io_stall = bus.io_req && wr_op && out_chan && fifo_full && !pop;
    assign accept       = bus.io_req && !bus.io_stall;
    assign wr_en        = accept && wr_op;
    assign push         = wr_en && out_chan;

    // Processor writes win a same-channel collision; the peripheral retries.
    assign bus.per_in_ready = !(wr_en && (bus.per_in_chan == bus.io_chan));
    assign per_wr           = bus.per_in_valid && bus.per_in_ready && bus.per_in_chan[CW-1];

    always_comb begin
        chan_d = chan_q;
        if (per_wr) chan_d[bus.per_in_chan] = bus.per_in_data;
        if (wr_en)  chan_d[bus.io_chan]     = result;
    end

    always_comb begin
        io_ack_d   = accept;
        io_rdata_d = accept ? result : io_rdata_q;
    end

    always_ff @(posedge clock or negedge rst_l) begin
        if (!rst_l) begin
            for (int i = 0; i < int'(NUM_CHAN); i++) chan_q[i] <= '0;
            io_ack_q   <= 1'b0;
            io_rdata_q <= '0;
        end else begin
            chan_q     <= chan_d;
            io_ack_q   <= io_ack_d;
            io_rdata_q <= io_rdata_d;
        end
    end

    assign bus.io_ack   = io_ack_q;
    assign bus.io_rdata = io_rdata_q;

    io_event_fifo #(
        .WIDTH (EW),
        .DEPTH (OUT_FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .rst_l   (rst_l),
        .push_i  (push),
        .din_i   ({bus.io_chan, result}),
        .pop_i   (pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .dout_o  (fifo_dout)
    );

    assign bus.per_out_valid = !fifo_empty;
    assign {bus.per_out_chan, bus.per_out_data} = fifo_dout;

endmodule

// File: tb/tb_io_channel_unit.sv
// Directed self-checking bench for io_channel_unit.
module tb_io_channel_unit;
    import io_channel_unit_pkg::*;

    logic clock = 1'b0;
    logic rst_l = 1'b0;
    int   checks = 0;
    int   failures = 0;

    io_channel_unit_if #(.NUM_CHAN(16), .WIDTH(15)) bus ();

    io_channel_unit #(.NUM_CHAN(16), .WIDTH(15), .OUT_FIFO_DEPTH(4)) dut (
        .clock (clock),
        .rst_l (rst_l),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input io_op_t op, input logic [3:0] ch, input logic [14:0] w);
        bus.io_req   = 1'b1;
        bus.io_op    = op;
        bus.io_chan  = ch;
        bus.io_wdata = w;
        step();
        bus.io_req   = 1'b0;
    endtask

    task automatic per_write(input logic [3:0] ch, input logic [14:0] d);
        bus.per_in_valid = 1'b1;
        bus.per_in_chan  = ch;
        bus.per_in_data  = d;
        step();
        bus.per_in_valid = 1'b0;
    endtask

    task automatic test_reset();
        bus.io_req = 1'b0; bus.io_op = IO_READ; bus.io_chan = '0; bus.io_wdata = '0;
        bus.per_in_valid = 1'b0; bus.per_in_chan = '0; bus.per_in_data = '0;
        bus.per_out_ready = 1'b0;
        rst_l = 1'b0;
        repeat (2) step();
        checks++; if (bus.io_ack !== 1'b0) begin failures++; $display("FAIL reset_ack: got %b exp 0", bus.io_ack); end
        checks++; if (bus.io_rdata !== 15'h0) begin failures++; $display("FAIL reset_rdata: got %h exp 0", bus.io_rdata); end
        checks++; if (bus.per_out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b exp 0", bus.per_out_valid); end
        checks++; if ({bus.per_out_chan, bus.per_out_data} !== 19'h0) begin failures++; $display("FAIL reset_out_payload: got %h exp 0", {bus.per_out_chan, bus.per_out_data}); end
        checks++; if (bus.per_in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b exp 1", bus.per_in_ready); end
        checks++; if (bus.io_stall !== 1'b0) begin failures++; $display("FAIL reset_stall: got %b exp 0", bus.io_stall); end
        rst_l = 1'b1;
        step();
    endtask

    task automatic test_read_init();
        issue(IO_READ, 4'd9, 15'h7FFF);
        checks++; if (bus.io_ack !== 1'b1) begin failures++; $display("FAIL read_init_ack: got %b exp 1", bus.io_ack); end
        checks++; if (bus.io_rdata !== 15'h0) begin failures++; $display("FAIL read_init_rdata: got %h exp 0", bus.io_rdata); end
        checks++; if (bus.per_out_valid !== 1'b0) begin failures++; $display("FAIL read_init_no_event: got %b exp 0", bus.per_out_valid); end
        step();
        checks++; if (bus.io_ack !== 1'b0) begin failures++; $display("FAIL ack_single_pulse: got %b exp 0", bus.io_ack); end
        checks++; if (bus.io_rdata !== 15'h0) begin failures++; $display("FAIL rdata_hold: got %h exp 0", bus.io_rdata); end
    endtask

    task automatic test_per_in_rand();
        bus.per_in_valid = 1'b1; bus.per_in_chan = 4'd9; bus.per_in_data = 15'h1234;
        #1;
        checks++; if (bus.per_in_ready !== 1'b1) begin failures++; $display("FAIL per_in_ready_idle: got %b exp 1", bus.per_in_ready); end
        step();
        bus.per_in_valid = 1'b0;
        issue(IO_RAND, 4'd9, 15'h00FF);
        checks++; if (bus.io_rdata !== 15'h0034) begin failures++; $display("FAIL rand_ch9: got %h exp 0034", bus.io_rdata); end
        issue(IO_READ, 4'd9, 15'h0);
        checks++; if (bus.io_rdata !== 15'h1234) begin failures++; $display("FAIL rand_no_write: got %h exp 1234", bus.io_rdata); end
        issue(IO_ROR, 4'd9, 15'h000F);
        checks++; if (bus.io_rdata !== 15'h123F) begin failures++; $display("FAIL ror_ch9: got %h exp 123f", bus.io_rdata); end
        checks++; if (bus.per_out_valid !== 1'b0) begin failures++; $display("FAIL read_ops_no_event: got %b exp 0", bus.per_out_valid); end
    endtask

    task automatic test_input_chan_ops();
        issue(IO_WRITE, 4'd12, 15'h0ABC);
        checks++; if (bus.io_rdata !== 15'h0ABC) begin failures++; $display("FAIL write_ch12: got %h exp 0abc", bus.io_rdata); end
        checks++; if (bus.per_out_valid !== 1'b0) begin failures++; $display("FAIL input_write_no_event: got %b exp 0", bus.per_out_valid); end
        issue(IO_RXOR, 4'd12, 15'h0FF0);
        checks++; if (bus.io_rdata !== 15'h054C) begin failures++; $display("FAIL rxor_ch12: got %h exp 054c", bus.io_rdata); end
        issue(IO_WAND, 4'd12, 15'h00F0);
        checks++; if (bus.io_rdata !== 15'h00B0) begin failures++; $display("FAIL wand_ch12: got %h exp 00b0", bus.io_rdata); end
        issue(IO_READ, 4'd12, 15'h0);
        checks++; if (bus.io_rdata !== 15'h00B0) begin failures++; $display("FAIL wand_ch12_stored: got %h exp 00b0", bus.io_rdata); end
        per_write(4'd3, 15'h5555);
        issue(IO_READ, 4'd3, 15'h0);
        checks++; if (bus.io_rdata !== 15'h0000) begin failures++; $display("FAIL per_in_out_chan_discard: got %h exp 0000", bus.io_rdata); end
    endtask

    task automatic test_write_wor();
        issue(IO_WRITE, 4'd2, 15'h7000);
        checks++; if (bus.io_rdata !== 15'h7000) begin failures++; $display("FAIL write_ch2: got %h exp 7000", bus.io_rdata); end
        checks++; if (bus.per_out_valid !== 1'b1) begin failures++; $display("FAIL event_latency: got %b exp 1", bus.per_out_valid); end
        issue(IO_WOR, 4'd2, 15'h000F);
        checks++; if (bus.io_rdata !== 15'h700F) begin failures++; $display("FAIL wor_ch2: got %h exp 700f", bus.io_rdata); end
        bus.per_out_ready = 1'b1;
        checks++; if ({bus.per_out_chan, bus.per_out_data} !== {4'd2, 15'h7000}) begin failures++; $display("FAIL event0: got %h exp %h", {bus.per_out_chan, bus.per_out_data}, {4'd2, 15'h7000}); end
        step();
        checks++; if ({bus.per_out_valid, bus.per_out_chan, bus.per_out_data} !== {1'b1, 4'd2, 15'h700F}) begin failures++; $display("FAIL event1: got %h exp %h", {bus.per_out_valid, bus.per_out_chan, bus.per_out_data}, {1'b1, 4'd2, 15'h700F}); end
        step();
        checks++; if (bus.per_out_valid !== 1'b0) begin failures++; $display("FAIL fifo_drained: got %b exp 0", bus.per_out_valid); end
        bus.per_out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        issue(IO_WRITE, 4'd5, 15'h2AAA);
        checks++; if ({bus.io_ack, bus.io_rdata} !== {1'b1, 15'h2AAA}) begin failures++; $display("FAIL b2b_write: got %h exp %h", {bus.io_ack, bus.io_rdata}, {1'b1, 15'h2AAA}); end
        issue(IO_READ, 4'd5, 15'h0);
        checks++; if ({bus.io_ack, bus.io_rdata} !== {1'b1, 15'h2AAA}) begin failures++; $display("FAIL b2b_read: got %h exp %h", {bus.io_ack, bus.io_rdata}, {1'b1, 15'h2AAA}); end
        checks++; if ({bus.per_out_chan, bus.per_out_data} !== {4'd5, 15'h2AAA}) begin failures++; $display("FAIL b2b_event: got %h exp %h", {bus.per_out_chan, bus.per_out_data}, {4'd5, 15'h2AAA}); end
        bus.per_out_ready = 1'b1;
        step();
        bus.per_out_ready = 1'b0;
    endtask

    task automatic test_fifo_full();
        logic [14:0] exp_d;
        bus.per_out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            bus.io_req = 1'b1; bus.io_op = IO_WRITE; bus.io_chan = 4'd1; bus.io_wdata = 15'(16'h0100 + i);
            #1;
            checks++; if (bus.io_stall !== 1'b0) begin failures++; $display("FAIL fill_stall_%0d: got %b exp 0", i, bus.io_stall); end
            step();
        end
        bus.io_wdata = 15'h0105;
        #1;
        checks++; if (bus.io_stall !== 1'b1) begin failures++; $display("FAIL full_stall: got %b exp 1", bus.io_stall); end
        step();
        checks++; if (bus.io_ack !== 1'b0) begin failures++; $display("FAIL stalled_no_ack: got %b exp 0", bus.io_ack); end
        bus.io_op = IO_READ;
        #1;
        checks++; if (bus.io_stall !== 1'b0) begin failures++; $display("FAIL read_never_stalls: got %b exp 0", bus.io_stall); end
        bus.io_op = IO_WRITE;
        bus.per_out_ready = 1'b1;
        #1;
        checks++; if (bus.io_stall !== 1'b0) begin failures++; $display("FAIL full_pop_unstall: got %b exp 0", bus.io_stall); end
        checks++; if (bus.per_out_data !== 15'h0101) begin failures++; $display("FAIL full_head: got %h exp 0101", bus.per_out_data); end
        step();
        bus.io_req = 1'b0;
        checks++; if ({bus.io_ack, bus.io_rdata} !== {1'b1, 15'h0105}) begin failures++; $display("FAIL fifth_accept: got %h exp %h", {bus.io_ack, bus.io_rdata}, {1'b1, 15'h0105}); end
        for (int i = 2; i <= 5; i++) begin
            exp_d = 15'(16'h0100 + i);
            checks++; if ({bus.per_out_valid, bus.per_out_chan, bus.per_out_data} !== {1'b1, 4'd1, exp_d}) begin failures++; $display("FAIL full_order_%0d: got %h exp %h", i, {bus.per_out_valid, bus.per_out_chan, bus.per_out_data}, {1'b1, 4'd1, exp_d}); end
            step();
        end
        checks++; if (bus.per_out_valid !== 1'b0) begin failures++; $display("FAIL full_drained: got %b exp 0", bus.per_out_valid); end
        bus.per_out_ready = 1'b0;
    endtask

    task automatic test_collision();
        per_write(4'd10, 15'h0F0F);
        bus.io_req = 1'b1; bus.io_op = IO_WAND; bus.io_chan = 4'd10; bus.io_wdata = 15'h00FF;
        bus.per_in_valid = 1'b1; bus.per_in_chan = 4'd10; bus.per_in_data = 15'h3333;
        #1;
        checks++; if (bus.per_in_ready !== 1'b0) begin failures++; $display("FAIL collide_ready: got %b exp 0", bus.per_in_ready); end
        step();
        checks++; if (bus.io_rdata !== 15'h000F) begin failures++; $display("FAIL collide_wand: got %h exp 000f", bus.io_rdata); end
        bus.io_op = IO_READ;
        #1;
        checks++; if (bus.per_in_ready !== 1'b1) begin failures++; $display("FAIL retry_ready: got %b exp 1", bus.per_in_ready); end
        step();
        bus.per_in_valid = 1'b0;
        checks++; if (bus.io_rdata !== 15'h000F) begin failures++; $display("FAIL same_cycle_read_old: got %h exp 000f", bus.io_rdata); end
        step();
        bus.io_req = 1'b0;
        checks++; if (bus.io_rdata !== 15'h3333) begin failures++; $display("FAIL retry_landed: got %h exp 3333", bus.io_rdata); end
    endtask

    task automatic test_reset_mid();
        bus.per_out_ready = 1'b0;
        issue(IO_WRITE, 4'd0, 15'h0011);
        issue(IO_WRITE, 4'd1, 15'h0022);
        issue(IO_WRITE, 4'd3, 15'h0033);
        per_write(4'd14, 15'h4444);
        issue(IO_WRITE, 4'd13, 15'h0055);
        checks++; if ({bus.io_ack, bus.per_out_valid} !== 2'b11) begin failures++; $display("FAIL pre_reset_state: got %b exp 11", {bus.io_ack, bus.per_out_valid}); end
        #2 rst_l = 1'b0;
        #1;
        checks++; if (bus.io_ack !== 1'b0) begin failures++; $display("FAIL mid_reset_ack: got %b exp 0", bus.io_ack); end
        checks++; if (bus.per_out_valid !== 1'b0) begin failures++; $display("FAIL mid_reset_fifo: got %b exp 0", bus.per_out_valid); end
        step();
        rst_l = 1'b1;
        step();
        for (int c = 0; c < 16; c++) begin
            issue(IO_READ, 4'(c), 15'h0);
            checks++; if (bus.io_rdata !== 15'h0) begin failures++; $display("FAIL post_reset_ch%0d: got %h exp 0", c, bus.io_rdata); end
        end
        checks++; if (bus.per_out_valid !== 1'b0) begin failures++; $display("FAIL post_reset_no_event: got %b exp 0", bus.per_out_valid); end
    endtask

    initial begin
        test_reset();
        test_read_init();
        test_per_in_rand();
        test_input_chan_ops();
        test_write_wor();
        test_back_to_back();
        test_fifo_full();
        test_collision();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/io_channel_unit.md
# io_channel_unit

Processor-side I/O channel responder. It services the execute-stage channel instructions (READ, WRITE, RAND, WAND, ROR, WOR, RXOR) against a bank of 15-bit channel registers. It accepts asynchronous peripheral updates on input channels and streams every processor write to an output channel to the peripheral side through a small event FIFO. It is the responder end of the IO_write_en/IO-read path that the hazard logic tracks.

## Interface
- NUM_CHAN, 16, number of channel registers; must be a power of 2, ≥2
- WIDTH, 15, channel word width (AGC word)
- OUT_FIFO_DEPTH, 4, depth of the outbound event FIFO; power of 2, ≥2
- clock  in  1  single clock, rising edge
- rst_l  in  1  reset, asynchronous, active-low
- io_req  in  1  processor channel request valid
- io_op  in  io_op_t (3)  channel operation
- io_chan  in  $clog2(NUM_CHAN)  target channel
- io_wdata  in  WIDTH  operand (accumulator value)
- io_stall  out  1  request cannot be accepted this cycle (combinational)
- io_ack  out  1  one-cycle pulse, result valid
- io_rdata  out  WIDTH  value returned to the accumulator
- per_in_valid  in  1  peripheral update valid
- per_in_chan  in  $clog2(NUM_CHAN)  peripheral target channel
- per_in_data  in  WIDTH  peripheral data
- per_in_ready  out  1  peripheral update accepted (combinational)
- per_out_valid  out  1  outbound event available
- per_out_chan  out  $clog2(NUM_CHAN)  channel written
- per_out_data  out  WIDTH  new channel value
- per_out_ready  in  1  peripheral consumes the event

## Operation
- Channels 0..NUM_CHAN/2-1 are output channels. Channels NUM_CHAN/2..NUM_CHAN-1 are input channels.
- Processor acceptance: io_req && !io_stall. Let r = chan[io_chan] at the start of the cycle and w = io_wdata.
  - READ: rdata = r; no write.
  - WRITE: new = w; rdata = w.
  - RAND: rdata = r & w; no write.
  - WAND: new = r & w; rdata = new.
  - ROR: rdata = r | w; no write.
  - WOR: new = r | w; rdata = new.
  - RXOR: rdata = r ^ w; no write.
- Write-type ops (WRITE, WAND, WOR) update any channel.
- A write-type op to an output channel pushes {io_chan, new} into the event FIFO. The push happens on every such write, whether or not the value changed.
- io_stall = io_req && write-type op && output channel && FIFO full && !(per_out_valid && per_out_ready). Read-type ops never stall.
- Peripheral update: accepted on per_in_valid && per_in_ready.
  - Input channel: chan[per_in_chan] <= per_in_data.
  - Output channel: the update is accepted and discarded.
- Collision rule: per_in_ready = !(accepted processor write-type op to the same channel this cycle). The processor always wins, and the peripheral retries next cycle.
- FIFO: per_out_valid = !empty. Head is on per_out_chan/per_out_data. Pop on per_out_valid && per_out_ready.
  - Push and pop in the same cycle are legal when full or empty. When empty, data is visible the next cycle; there is no fall-through.
  - Events are delivered in order of acceptance.

## Timing
- Reset values:
  - All channels 0, FIFO empty.
  - io_ack=0, io_rdata=0.
  - per_out_valid=0, per_out_chan=0, per_out_data=0.
  - per_in_ready=1.
  - io_stall=0 unless io_req is asserted.
- Processor latency is 1. Acceptance in cycle N gives io_ack=1 with io_rdata in cycle N+1. io_ack is low otherwise, and io_rdata holds its last value.
- Back-to-back accepted requests are supported, one per cycle. A read in N+1 sees a write accepted in N.
- A peripheral update accepted in cycle N is visible to a processor read accepted in N+1. A same-cycle processor read sees the pre-update value.
- An event pushed in cycle N appears on per_out_* in N+1 when the FIFO was empty.
- Reset mid-operation clears any pending io_ack and drops all FIFO contents. No partial effects survive.
- FIFO count wraps on power-of-2 pointers with an extra bit to distinguish full from empty.

## Structure
- io_op_t (IO_READ, IO_WRITE, IO_RAND, IO_WAND, IO_ROR, IO_WOR, IO_RXOR) and a write-type predicate constant set go in the shared internal_defines package next to ctrl_t.
- Sub-module io_event_fifo (synchronous FIFO with parameters WIDTH and DEPTH, push/pop/full/empty). It is instantiated once with width $clog2(NUM_CHAN)+WIDTH.
- Channel bank, op ALU and response register live in io_channel_unit.

## Test plan
- Reset, then READ ch9 → io_ack next cycle, io_rdata=0; per_out_valid stays 0.
- per_in write ch9=0x1234, then RAND ch9 w=0x00FF → io_rdata=0x0034; ch9 unchanged (READ returns 0x1234).
- WRITE ch2=0x7000, then WOR ch2 w=0x000F → rdata 0x700F. Two events in order are delivered: (2,0x7000), (2,0x700F).
- per_out_ready=0; five WRITEs to ch1 → first four accepted, fifth sees io_stall=1. Raise per_out_ready → fifth is accepted in the same cycle as the pop, and FIFO order is preserved.
- Same-cycle WAND ch10 and per_in ch10 → per_in_ready=0, processor result is applied, peripheral write lands next cycle.
- FIFO holding 3 events with an ack pending; assert rst_l=0 mid-cycle → per_out_valid=0 and io_ack=0 immediately, all channels read 0 after release.
